// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: instruction-cache miss handler.
// On a miss it stalls fetch, bursts eight pipelined 2-byte reads covering the
// 16-byte block, writes each returned word into the data array in arrival
// order and, with the last word, writes tag/valid into the meta-data array.
module icache_fill_ctrl #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        memory_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        write_tag_array,
    output logic [5:0]  fill_set,
    output logic [5:0]  fill_tag
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      base_q, base_d;       // block base address, low 4 bits zero
    logic [CNT_W:0]   issue_cnt_q, issue_cnt_d; // reads issued, 0..WORDS_PER_BLOCK
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;     // returns consumed, wraps after last

    // Set and tag are slices of the latched base, so they persist after a fill.
    assign fill_set  = base_q[9:4];
    assign fill_tag  = base_q[15:10];
    assign fill_word = ret_cnt_q;

    // State and counter registers; reset abandons any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other; blocking here would chain them.
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // Next-state logic plus all outputs: issue side and return side run independently.
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        fill_data        = 16'h0000;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                // Stall in the miss cycle itself; stray returns are ignored here.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d      = miss_address & 16'hFFF0;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                // One read per cycle until the whole block has been requested.
                // Offset stays below 16, so the sum never carries out of the block.
                if (issue_cnt_q < (CNT_W + 1)'(WORDS_PER_BLOCK)) begin
                    memory_read_en = 1'b1;
                    memory_address = base_q + 16'({issue_cnt_q[CNT_W-1:0], 1'b0});
                    issue_cnt_d    = issue_cnt_q + (CNT_W + 1)'(1);
                end

                // Returns are counted, not timed: any gap pattern is accepted.
                write_data_array = memory_data_valid;
                fill_data        = memory_data;
                if (memory_data_valid) begin
                    ret_cnt_d = ret_cnt_q + CNT_W'(1);
                    if (ret_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: a latency-3 memory model feeds a
// scoreboard of expected data-array writes, and each scenario task checks
// cycle-exact control outputs against the documented timing.
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [5:0]  fill_set;
    logic [5:0]  fill_tag;

    icache_fill_ctrl #(.WORDS_PER_BLOCK(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_set          (fill_set),
        .fill_tag          (fill_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    typedef struct {
        logic [2:0]  word;
        logic [15:0] data;
    } wr_t;

    ret_t mem_q[$];   // pending memory returns, in order
    wr_t  wr_q[$];    // expected data-array writes, in order

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_tag    = 0;
    int          last_due = -1000;
    int          gap_max  = 0;
    logic [2:0]  issue_k  = 3'd0;
    logic [15:0] exp_base = 16'h0000;

    // Outputs sampled mid-cycle by tick().
    logic        s_busy, s_ren, s_wda, s_wta;
    logic [15:0] s_addr, s_data;
    logic [2:0]  s_word;
    logic [5:0]  s_set, s_tag;

    // One clock cycle: drive memory returns at the falling edge, sample and
    // score outputs just after, then advance past the rising edge.
    task automatic tick();
        ret_t r;
        wr_t  w;
        logic popped7;
        @(negedge clk);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = r.data;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
        #1;
        s_busy = fsm_busy;
        s_ren  = memory_read_en;
        s_addr = memory_address;
        s_wda  = write_data_array;
        s_wta  = write_tag_array;
        s_word = fill_word;
        s_data = fill_data;
        s_set  = fill_set;
        s_tag  = fill_tag;
        popped7 = 1'b0;

        n_checks++;
        if (s_ren) begin
            if (s_addr !== exp_base + {12'h000, issue_k, 1'b0}) begin
                n_errors++;
                $display("FAIL read_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_base + {12'h000, issue_k, 1'b0});
            end
            r.due = cyc + 3;
            if (last_due + 1 + int'($urandom_range(0, gap_max)) > r.due)
                r.due = last_due + 1 + int'($urandom_range(0, gap_max));
            r.data = s_addr ^ 16'hC3A5;
            last_due = r.due;
            mem_q.push_back(r);
            w.word = issue_k;
            w.data = r.data;
            wr_q.push_back(w);
            issue_k++;
        end else if (s_addr !== 16'h0000) begin
            n_errors++;
            $display("FAIL idle_addr cyc=%0d got=%h exp=0000", cyc, s_addr);
        end

        if (s_wda) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write cyc=%0d word=%0d data=%h exp=no write", cyc, s_word, s_data);
            end else begin
                w = wr_q.pop_front();
                popped7 = (w.word == 3'd7);
                if ({s_word, s_data} !== {w.word, w.data}) begin
                    n_errors++;
                    $display("FAIL data_write cyc=%0d got word=%0d data=%h exp word=%0d data=%h",
                             cyc, s_word, s_data, w.word, w.data);
                end
            end
        end

        if (s_wta) begin
            n_tag++;
            n_checks++;
            if (!popped7 || s_tag !== exp_base[15:10] || s_set !== exp_base[9:4]) begin
                n_errors++;
                $display("FAIL tag_write cyc=%0d last_word=%0b tag=%h set=%h exp last_word=1 tag=%h set=%h",
                         cyc, popped7, s_tag, s_set, exp_base[15:10], exp_base[9:4]);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        #12;
        n_checks++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl got=%b exp=0000", {fsm_busy, memory_read_en, write_data_array, write_tag_array});
        end
        n_checks++;
        if ({memory_address, fill_data} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_bus got addr=%h data=%h exp 0", memory_address, fill_data);
        end
        n_checks++;
        if ({fill_word, fill_set, fill_tag} !== 15'h0) begin
            n_errors++;
            $display("FAIL reset_fill got word=%0d set=%h tag=%h exp 0", fill_word, fill_set, fill_tag);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_fill();
        logic exp_busy, exp_ren, exp_wda, exp_wta;
        exp_base = 16'h1230;
        issue_k  = 3'd0;
        miss_address = 16'h1234;
        for (int c = 0; c < 15; c++) begin
            miss_detected = (c == 0);
            tick();
            exp_busy = (c <= 11);
            exp_ren  = (c >= 1 && c <= 8);
            exp_wda  = (c >= 4 && c <= 11);
            exp_wta  = (c == 11);
            n_checks++;
            if ({s_busy, s_ren, s_wda, s_wta} !== {exp_busy, exp_ren, exp_wda, exp_wta}) begin
                n_errors++;
                $display("FAIL single_ctrl c=%0d got busy/ren/wda/wta=%b exp=%b",
                         c, {s_busy, s_ren, s_wda, s_wta}, {exp_busy, exp_ren, exp_wda, exp_wta});
            end
            if (exp_wda) begin
                n_checks++;
                if (s_word !== 3'(c - 4)) begin
                    n_errors++;
                    $display("FAIL single_word c=%0d got=%0d exp=%0d", c, s_word, 3'(c - 4));
                end
            end
        end
        miss_detected = 1'b0;
        n_checks++;
        if (s_tag !== 6'h04 || s_set !== 6'h23) begin
            n_errors++;
            $display("FAIL single_hold got tag=%h set=%h exp tag=04 set=23", s_tag, s_set);
        end
        n_checks++;
        if (wr_q.size() != 0 || mem_q.size() != 0) begin
            n_errors++;
            $display("FAIL single_drain got pending writes=%0d returns=%0d exp 0", wr_q.size(), mem_q.size());
        end
    endtask

    task automatic test_irregular();
        int n_wr = 0;
        int tag_before = n_tag;
        bit done = 1'b0;
        gap_max  = 3;
        exp_base = 16'hA5C0;
        issue_k  = 3'd0;
        miss_address = 16'hA5C8;
        for (int c = 0; c < 100 && !done; c++) begin
            miss_detected = (c == 0);
            tick();
            if (s_wda) n_wr++;
            if (s_wta) begin
                n_checks++;
                if (n_wr != 8) begin
                    n_errors++;
                    $display("FAIL irregular_tag_pos got=%0d exp=8", n_wr);
                end
            end
            if (c > 0 && !s_busy) done = 1'b1;
        end
        miss_detected = 1'b0;
        gap_max = 0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL irregular_timeout got busy=1 exp busy=0 within 100 cycles");
        end
        n_checks++;
        if (n_wr != 8 || n_tag - tag_before != 1) begin
            n_errors++;
            $display("FAIL irregular_count got writes=%0d tags=%0d exp writes=8 tags=1", n_wr, n_tag - tag_before);
        end
        n_checks++;
        if (wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL irregular_drain got=%0d exp=0", wr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_ren, exp_wta;
        exp_base = 16'h1230;
        issue_k  = 3'd0;
        for (int c = 0; c < 27; c++) begin
            miss_detected = (c <= 12);
            miss_address  = (c >= 4) ? 16'h8000 : 16'h1234;
            if (c == 12) exp_base = 16'h8000;
            tick();
            exp_busy = (c <= 23);
            exp_ren  = (c >= 1 && c <= 8) || (c >= 13 && c <= 20);
            exp_wta  = (c == 11) || (c == 23);
            n_checks++;
            if ({s_busy, s_ren, s_wta} !== {exp_busy, exp_ren, exp_wta}) begin
                n_errors++;
                $display("FAIL b2b_ctrl c=%0d got busy/ren/wta=%b exp=%b",
                         c, {s_busy, s_ren, s_wta}, {exp_busy, exp_ren, exp_wta});
            end
        end
        miss_detected = 1'b0;
        n_checks++;
        if (s_tag !== 6'h20 || s_set !== 6'h00) begin
            n_errors++;
            $display("FAIL b2b_second got tag=%h set=%h exp tag=20 set=00", s_tag, s_set);
        end
    endtask

    task automatic test_wrap();
        int n_rd = 0;
        int tag_before = n_tag;
        exp_base = 16'hFFF0;
        issue_k  = 3'd0;
        miss_address = 16'hFFFE;
        for (int c = 0; c < 15; c++) begin
            miss_detected = (c == 0);
            tick();
            if (s_ren) n_rd++;
            if (c == 8) begin
                n_checks++;
                if (s_ren !== 1'b1 || s_addr !== 16'hFFFE) begin
                    n_errors++;
                    $display("FAIL wrap_last got ren=%b addr=%h exp ren=1 addr=fffe", s_ren, s_addr);
                end
            end
        end
        miss_detected = 1'b0;
        n_checks++;
        if (n_rd != 8 || n_tag - tag_before != 1 || s_tag !== 6'h3F || s_set !== 6'h3F) begin
            n_errors++;
            $display("FAIL wrap_result got reads=%0d tags=%0d tag=%h set=%h exp 8 1 3f 3f",
                     n_rd, n_tag - tag_before, s_tag, s_set);
        end
    endtask

    task automatic test_reset_mid_fill();
        int tag_before = n_tag;
        exp_base = 16'h2340;
        issue_k  = 3'd0;
        miss_address = 16'h2346;
        for (int c = 0; c < 6; c++) begin
            miss_detected = (c == 0);
            tick();
        end
        miss_detected = 1'b0;
        // Cycle 6: assert reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000 ||
            {memory_address, fill_data, fill_word, fill_set, fill_tag} !== 47'h0) begin
            n_errors++;
            $display("FAIL reset_async got busy=%b ren=%b wda=%b wta=%b addr=%h data=%h word=%0d set=%h tag=%h exp all 0",
                     fsm_busy, memory_read_en, write_data_array, write_tag_array,
                     memory_address, fill_data, fill_word, fill_set, fill_tag);
        end
        wr_q.delete();
        issue_k = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 8; c < 14; c++) begin
            tick();
            n_checks++;
            if ({s_busy, s_wda, s_wta} !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_stray c=%0d got busy/wda/wta=%b exp=000", c, {s_busy, s_wda, s_wta});
            end
        end
        n_checks++;
        if (n_tag != tag_before || mem_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_notag got tags=%0d pending=%0d exp tags=0 pending=0", n_tag - tag_before, mem_q.size());
        end
        // A fresh miss after the aborted fill completes normally.
        exp_base = 16'h0AB0;
        issue_k  = 3'd0;
        miss_address = 16'h0ABC;
        for (int c = 0; c < 14; c++) begin
            miss_detected = (c == 0);
            tick();
        end
        miss_detected = 1'b0;
        n_checks++;
        if (n_tag - tag_before != 1 || wr_q.size() != 0 || s_set !== 6'h2B || s_tag !== 6'h02) begin
            n_errors++;
            $display("FAIL reset_refill got tags=%0d pending=%0d set=%h tag=%h exp 1 0 2b 02",
                     n_tag - tag_before, wr_q.size(), s_set, s_tag);
        end
    endtask

    task automatic test_idle_valid();
        ret_t r;
        int tag_before = n_tag;
        miss_detected = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r.due  = cyc + k + (k / 2);
            r.data = 16'hBEE0 + 16'(k);
            mem_q.push_back(r);
        end
        for (int c = 0; c < 7; c++) begin
            tick();
            n_checks++;
            if ({s_busy, s_wda, s_wta} !== 3'b000) begin
                n_errors++;
                $display("FAIL idle_valid c=%0d got busy/wda/wta=%b exp=000", c, {s_busy, s_wda, s_wta});
            end
        end
        n_checks++;
        if (n_tag != tag_before || mem_q.size() != 0) begin
            n_errors++;
            $display("FAIL idle_valid_end got tags=%0d pending=%0d exp 0 0", n_tag - tag_before, mem_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_irregular();
        test_back_to_back();
        test_wrap();
        test_reset_mid_fill();
        test_idle_valid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Miss-handling controller for the instruction cache. It sits between the cache arrays and main memory. On a miss it stalls the fetch stage and fetches the whole 16-byte block as a burst of eight pipelined 2-byte reads. Each returned word is written into the data array, and on the last word it writes tag/valid into the meta-data array.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, words per cache block. Fixed by the 16B block and 2B memory port.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous, active-high. Clears all state.
- miss_detected  in  1  tag compare failed for the current access.
- miss_address  in  16  byte address of the missing access. Sampled only when a fill starts.
- memory_data_valid  in  1  memory_data carries a read return.
- memory_data  in  16  read return data.
- fsm_busy  out  1  stall to fetch stage.
- memory_read_en  out  1  issue one 2-byte read this cycle.
- memory_address  out  16  read address. 0x0000 whenever memory_read_en=0.
- write_data_array  out  1  write fill_data into word fill_word of block fill_set.
- fill_word  out  3  word index within block.
- fill_data  out  16  data to data array.
- write_tag_array  out  1  write tag fill_tag, valid=1 into set fill_set (LRU way selected by meta-data array).
- fill_set  out  6  latched block base bits [9:4].
- fill_tag  out  6  latched block base bits [15:10].

## Operation
State is 2 states: IDLE and FILL.

Registers:
- base: 16 bits, low 4 bits always 0.
- issue_cnt: 0..8.
- ret_cnt: 0..7.

IDLE:
- When miss_detected=1: latch base = miss_address & 0xFFF0, clear both counters, go to FILL.
- memory_data_valid is ignored.

FILL, issue side:
- While issue_cnt<8: memory_read_en=1, memory_address = base + 2*issue_cnt, then issue_cnt++.
- One read is issued per cycle, with no back-pressure.

FILL, return side:
- write_data_array = memory_data_valid.
- fill_word = ret_cnt.
- fill_data = memory_data, combinational pass-through.
- On each valid return, ret_cnt++.
- Returns are counted, never timed. Gaps between valids are legal and the block waits indefinitely.

Completion:
- On a valid return with ret_cnt=7: write_tag_array=1 in the same cycle, then go to IDLE.

Other rules:
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). The stall is asserted in the miss cycle itself.
- miss_detected during FILL is ignored; base is not relatched.
- fill_set and fill_tag come from base and hold their value after the fill completes.
- Address arithmetic is 16-bit. With base 0xFFF0 the reads are 0xFFF0..0xFFFE, with no carry out of the block.
- Reset mid-fill: return to IDLE immediately and clear counters and base; no tag write. Returns still in flight arrive in IDLE and are discarded.

Reset values: all outputs 0, and fill_set/fill_tag = 0.

## Timing
Miss seen in IDLE at cycle 0. With the system memory, read issued at cycle t returns valid at t+3 (4-cycle read):
- cycle 0: fsm_busy=1; base latched at the edge ending cycle 0.
- cycles 1-8: memory_read_en=1, addresses base+0 .. base+14.
- cycles 4-11: write_data_array=1, fill_word 0..7.
- cycle 11: write_tag_array=1.
- cycle 12: state IDLE, fsm_busy=0 unless a new miss is asserted.

Miss penalty is 12 stall cycles. The cache re-performs the access in cycle 12 and hits.

A new miss in cycle 12 starts the next fill with no dead cycle.

## Test plan
- Single fill, miss_address=0x1234, memory model with latency 3:
  - reads 0x1230..0x123E in cycles 1-8;
  - words 0..7 written in cycles 4-11 with returned data;
  - write_tag_array at cycle 11 with fill_tag=0x04, fill_set=0x23;
  - fsm_busy high in cycles 0-11.
- Irregular returns: memory inserts 0-3 idle cycles between valids.
  - Required: exactly 8 in-order data writes and one tag write, on the 8th valid.
- Miss held high through the whole fill with miss_address changing to 0x8000 mid-fill.
  - Required: all addresses stay at 0x1230 + 2k.
  - Required: a second fill starts at cycle 12 with base 0x8000.
- Wrap case, miss_address=0xFFFE.
  - Required: reads 0xFFF0..0xFFFE, fill_tag=0x3F, fill_set=0x3F.
- Reset asserted asynchronously in cycle 6 of a fill, released at cycle 8.
  - Required: all outputs 0 immediately; no write_tag_array.
  - Required: later stray valids produce no writes; a new miss then fills normally.
- memory_data_valid pulses while IDLE with no miss.
  - Required: no writes, fsm_busy=0.
